// File: rtl/round_sequencer.sv
// Round sequencer for a memory game: IDLE -> SHOW -> INPUT -> RESULT -> IDLE.
// Optional INPUT timeout is enabled by defining ROUND_TIMEOUT_EN.
module round_sequencer #(
  parameter int TICK_DIV    = 10,
  parameter int SHOW_TICKS  = 3,
  parameter int INPUT_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       input_done,
  input  logic       match,
  output logic       tick,
  output logic       show_en,
  output logic       input_en,
  output logic       win,
  output logic       lose,
  output logic [3:0] level,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHOW, INPUT, RESULT} state_e;

  localparam logic [7:0] PMAX = 8'(TICK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [3:0] level_q, level_d;
  logic       won_q, won_d;
  logic       tick_w, show_last, timeout;
  logic [4:0] tcnt_inc;

  assign tick_w    = (state_q != IDLE) && (presc_q == PMAX);
  assign tcnt_inc  = {1'b0, tcnt_q} + 5'd1;
  assign show_last = tick_w && (tcnt_inc == 5'(SHOW_TICKS));

`ifdef ROUND_TIMEOUT_EN
  assign timeout = tick_w && (tcnt_inc == 5'(INPUT_TICKS));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    level_d = level_q;
    won_d   = won_q;
    if (state_q != IDLE) begin
      presc_d = tick_w ? 8'd0 : presc_q + 8'd1;
      if (tick_w && tcnt_q != 4'hF) tcnt_d = tcnt_q + 4'd1;
    end
    case (state_q)
      IDLE:   if (start) state_d = SHOW;
      SHOW:   if (show_last) state_d = INPUT;
      INPUT: begin
        // a player's entry wins over a timeout tick in the same cycle
        if (input_done) begin
          state_d = RESULT;
          won_d   = match;
        end else if (timeout) begin
          state_d = RESULT;
          won_d   = 1'b0;
        end
      end
      RESULT: begin
        state_d = IDLE;
        if (won_q) level_d = (level_q == 4'hF) ? 4'hF : level_q + 4'd1;
        else       level_d = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    // every transition is a state entry: timing restarts from zero
    if (state_d != state_q) begin
      presc_d = 8'd0;
      tcnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= 8'd0;
      tcnt_q  <= 4'd0;
      level_q <= 4'd0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      level_q <= level_d;
      won_q   <= won_d;
    end
  end

  assign tick     = tick_w;
  assign show_en  = (state_q == SHOW);
  assign input_en = (state_q == INPUT);
  assign win      = (state_q == RESULT) && won_q;
  assign lose     = (state_q == RESULT) && !won_q;
  assign level    = level_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: cycle-count reference model plus directed and random rounds.
module tb_round_sequencer;
  localparam int TD = 4;
  localparam int ST = 2;
  localparam int IT = 3;
`ifdef ROUND_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, input_done = 1'b0, match = 1'b0;
  logic       tick, show_en, input_en, win, lose, busy;
  logic [3:0] level;

  round_sequencer #(.TICK_DIV(TD), .SHOW_TICKS(ST), .INPUT_TICKS(IT)) dut (
    .clk(clk), .rst(rst), .start(start), .input_done(input_done), .match(match),
    .tick(tick), .show_en(show_en), .input_en(input_en), .win(win), .lose(lose),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  // Reference: phase plus cycles spent in it; ticks fall where cyc mod TD == TD-1.
  int  ph  = 0;   // 0 idle, 1 show, 2 input, 3 result
  int  cyc = 0;
  int  lvl = 0;
  bit  won = 0;
  bit  mvalid = 0;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; cyc = 0; lvl = 0; won = 0;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; cyc = 0; end
        1: if (cyc == ST * TD - 1) begin ph = 2; cyc = 0; end else cyc++;
        2: if (input_done) begin ph = 3; won = match; cyc = 0; end
           else if (TO && cyc == IT * TD - 1) begin ph = 3; won = 0; cyc = 0; end
           else cyc++;
        default: begin
          ph = 0; cyc = 0;
          lvl = won ? ((lvl < 15) ? lvl + 1 : 15) : 0;
        end
      endcase
    end
    mvalid = 1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy",     busy,     int'(ph != 0));
      chk("tick",     tick,     int'(ph != 0 && (cyc % TD) == TD - 1));
      chk("show_en",  show_en,  int'(ph == 1));
      chk("input_en", input_en, int'(ph == 2));
      chk("win",      win,      int'(ph == 3 && won));
      chk("lose",     lose,     int'(ph == 3 && !won));
      chk("level",    level,    lvl);
    end
  end

  int show_cnt = 0, win_cnt = 0, lose_cnt = 0;
  always @(negedge clk) begin
    if (show_en) show_cnt++;
    if (win)     win_cnt++;
    if (lose)    lose_cnt++;
  end

  task automatic wait_in();
    int n = 0;
    while (!input_en && n < 200) begin @(negedge clk); n++; end
    if (!input_en) bound_fail("wait_input_en");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) bound_fail("wait_idle");
  endtask

  // Drive input_done with match m during the k-th INPUT cycle; noise pokes SHOW.
  task automatic play(input bit m, input int k, input bit noise);
    start = 1'b1; @(negedge clk); start = 1'b0;
    if (noise) begin
      repeat (3) @(negedge clk);
      start = 1'b1; input_done = 1'b1; match = 1'b1;
      @(negedge clk);
      start = 1'b0; input_done = 1'b0; match = 1'b0;
    end
    wait_in();
    repeat (k - 1) @(negedge clk);
    input_done = 1'b1; match = m;
    @(negedge clk);
    input_done = 1'b0; match = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int w0, l0, n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // win path from level 0
    show_cnt = 0; w0 = win_cnt;
    play(1'b1, 2, 1'b0);
    chk("win_show_cycles", show_cnt, 8);
    chk("win_pulses", win_cnt - w0, 1);
    chk("win_level", level, 1);

    // climb to 3, then lose
    play(1'b1, 1, 1'b0);
    play(1'b1, 3, 1'b0);
    chk("lvl3", level, 3);
    l0 = lose_cnt;
    play(1'b0, 2, 1'b0);
    chk("loss_pulses", lose_cnt - l0, 1);
    chk("loss_level", level, 0);

    // timeout behaviour
    l0 = lose_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_in();
    if (TO) begin
      n = 1;
      while (!lose && n < 50) begin
        @(negedge clk);
        if (input_en) n++;
      end
      chk("timeout_input_cycles", n, 12);
      chk("timeout_lose", lose, 1);
      wait_idle();
    end else begin
      repeat (40) @(negedge clk);
      chk("notimeout_input_en", input_en, 1);
      chk("notimeout_no_lose", lose_cnt - l0, 0);
      input_done = 1'b1; @(negedge clk); input_done = 1'b0;
      wait_idle();
    end

    // entry on the timeout tick wins
    w0 = win_cnt; l0 = lose_cnt;
    play(1'b1, 12, 1'b0);
    chk("simul_win", win_cnt - w0, 1);
    chk("simul_no_lose", lose_cnt - l0, 0);

    // saturation and ignored SHOW-time inputs
    do_reset();
    for (int i = 0; i < 16; i++) play(1'b1, 2, 1'b0);
    chk("sat_level", level, 15);
    show_cnt = 0;
    play(1'b1, 1, 1'b1);
    chk("noise_show_cycles", show_cnt, 8);
    chk("sat_hold", level, 15);

    // reset during INPUT
    w0 = win_cnt; l0 = lose_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_in();
    repeat (2) @(negedge clk);
    do_reset();
    chk("abort_busy", busy, 0);
    chk("abort_level", level, 0);
    chk("abort_input_en", input_en, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_result", (win_cnt - w0) + (lose_cnt - l0), 0);

    // random rounds, model-checked every cycle
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        input_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        input_done = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        do_reset();
      end else begin
        play(1'($urandom_range(0, 3) != 0), $urandom_range(1, 14),
             1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 10: clk cycles per timing tick (legal 2..255).
REQ-002 Parameter SHOW_TICKS, default 3: ticks the pattern is displayed (legal 1..15).
REQ-003 Parameter INPUT_TICKS, default 5: ticks allowed for player entry (legal 1..15).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begins a round when sampled high in IDLE.
REQ-007 input_done  in  1  one-cycle pulse; player finished entry.
REQ-008 match  in  1  entry correct; qualified only by input_done.
REQ-009 tick  out  1  one-cycle timing pulse.
REQ-010 show_en  out  1  high throughout SHOW.
REQ-011 input_en  out  1  high throughout INPUT.
REQ-012 win  out  1  one-cycle pulse; round won.
REQ-013 lose  out  1  one-cycle pulse; round lost.
REQ-014 level  out  4  current game level.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States IDLE, SHOW, INPUT, RESULT; all outputs are registered and decoded from state or counters.
REQ-017 Prescaler (8-bit) runs only outside IDLE and clears to 0 on every state entry; counts 0..TICK_DIV-1 and wraps.
REQ-018 tick is high in the cycle the prescaler equals TICK_DIV-1; first tick after state entry falls on the TICK_DIV-th cycle in that state.
REQ-019 Tick counter (4-bit) clears on state entry and increments on each tick.
REQ-020 IDLE -> SHOW when start=1; start outside IDLE is ignored.
REQ-021 SHOW -> INPUT on the tick that makes the tick count equal SHOW_TICKS; SHOW lasts exactly SHOW_TICKS*TICK_DIV cycles.
REQ-022 INPUT -> RESULT on input_done; result is a win if match=1, otherwise a loss.
REQ-023 input_done outside INPUT is ignored.
REQ-024 INPUT timeout (see REQ-032) produces a loss.
REQ-025 If input_done and the timeout tick occur in the same cycle, input_done takes priority.
REQ-026 RESULT lasts one cycle, asserting exactly one of win or lose, then returns to IDLE.
REQ-027 On leaving RESULT, a win sets level to level+1, saturating at 15; a loss sets level to 0.
REQ-028 Reset asserted mid-round aborts the round immediately; no win or lose pulse is produced.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, prescaler=0, tick counter=0, level=0.
REQ-030 While rst=1: tick, show_en, input_en, win, lose and busy are all 0.
REQ-031 rst has priority over all other inputs.

Configuration
REQ-032 With macro ROUND_TIMEOUT_EN defined, INPUT moves to RESULT(lose) on the tick that makes the tick count equal INPUT_TICKS.
REQ-033 Without ROUND_TIMEOUT_EN, INPUT waits indefinitely for input_done.
REQ-034 Without ROUND_TIMEOUT_EN, tick still pulses in INPUT and the tick counter saturates at 15.

Verification (TICK_DIV=4, SHOW_TICKS=2, INPUT_TICKS=3)
REQ-035 Win path: start pulse -> show_en high 8 cycles, then input_en; input_done=1 with match=1 -> win high 1 cycle, level 0->1, busy low next cycle.
REQ-036 Loss path: reach level 3, then input_done=1 with match=0 -> lose pulse, level=0.
REQ-037 Timeout (macro on): no input_done -> lose on the 12th INPUT cycle. Macro off: input_en remains high after 40 cycles with no lose.
REQ-038 Simultaneous event: input_done with match=1 on the timeout tick -> win, no lose.
REQ-039 Saturation and ignored inputs: 16 consecutive wins -> level holds 15; start and input_done pulses during SHOW have no effect.
REQ-040 Reset mid-INPUT: rst=1 for 1 cycle -> IDLE, level=0, all outputs 0, no win or lose pulse.
